traffic_lights_cmd_seq: RTL and testbench

Command sequencer that drives the `cmd_*` input port of the traffic light controller. It accepts one high-level request at a time from a host over a valid/ready handshake. Each request expands into the exact command sequence the controller requires, with single-cycle `cmd_valid_o` pulses separated by a programmable gap. The block sits between the host/CSR logic and the traffic light controller and owns all protocol ordering, such as forcing yellow-blink before any timing write.

---
 rtl/traffic_lights_cmd_seq.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_traffic_lights_cmd_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : traffic_lights_cmd_seq
// Purpose  : Expands one high-level host request (ON / OFF / BLINK /
//            RECONFIG) into the ordered command sequence the traffic light
//            controller expects. Each command is a single-cycle cmd_valid_o
//            pulse, followed by GAP_CYCLES idle cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   GAP_CYCLES       idle cycles after every command (0 = back-to-back)
// Ports
//   clk_i            clock
//   arst_n_i         asynchronous active-low reset
//   req_valid_i      host request valid
//   req_ready_o      sequencer can accept a request
//   req_op_i         0=ON 1=OFF 2=BLINK 3=RECONFIG
//   req_green_ms_i   green time (RECONFIG only)
//   req_red_ms_i     red time (RECONFIG only)
//   req_yellow_ms_i  yellow time (RECONFIG only)
//   cmd_valid_o      command strobe to the controller
//   cmd_type_o       command type
//   cmd_data_o       command payload (0 unless a timing write is issued)
//   busy_o           sequence in progress
//   err_o            one-cycle pulse when a request is rejected
// Build option
//   TRAFFIC_CMD_SEQ_SKIP_UNCHANGED_EN : keep shadow copies of the controller
//   timings and skip timing writes whose value is already loaded.
// ============================================================================
module traffic_lights_cmd_seq #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [15:0] req_green_ms_i,
  input  logic [15:0] req_red_ms_i,
  input  logic [15:0] req_yellow_ms_i,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_type_o,
  output logic [15:0] cmd_data_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int c_cnt_w = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // GAP state runs from c_gap_load down to 0, i.e. GAP_CYCLES cycles.
  localparam logic [c_cnt_w-1:0] c_gap_load =
    c_cnt_w'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] c_op_on       = 2'd0;
  localparam logic [1:0] c_op_off      = 2'd1;
  localparam logic [1:0] c_op_blink    = 2'd2;
  localparam logic [1:0] c_op_reconfig = 2'd3;

  localparam logic [2:0] c_cmd_on     = 3'd0;
  localparam logic [2:0] c_cmd_off    = 3'd1;
  localparam logic [2:0] c_cmd_blink  = 3'd2;
  localparam logic [2:0] c_cmd_green  = 3'd3;
  localparam logic [2:0] c_cmd_red    = 3'd4;
  localparam logic [2:0] c_cmd_yellow = 3'd5;

  // RECONFIG slot numbering: 0=blink, 1=green, 2=red, 3=yellow, 4=on.
  // Non-RECONFIG ops use slot 0 only.
  localparam logic [2:0] c_slot_first  = 3'd0;
  localparam logic [2:0] c_slot_green  = 3'd1;
  localparam logic [2:0] c_slot_red    = 3'd2;
  localparam logic [2:0] c_slot_yellow = 3'd3;
  localparam logic [2:0] c_slot_last   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [2:0]         r_idx;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_op;
  logic [15:0]        r_green;
  logic [15:0]        r_red;
  logic [15:0]        r_yellow;
  logic               r_cmd_valid;
  logic [2:0]         r_cmd_type;
  logic [15:0]        r_cmd_data;
  logic               r_ready;
  logic               r_busy;
  logic               r_err;

  state_t             w_state_n;
  logic [2:0]         w_idx_n;
  logic [c_cnt_w-1:0] w_cnt_n;
  logic               w_valid_n;
  logic [2:0]         w_type_n;
  logic [15:0]        w_data_n;
  logic               w_ready_n;
  logic               w_err_n;

  logic               w_accept;
  logic               w_reject;
  logic [2:0]         w_first_type;
  logic               w_need_green;
  logic               w_need_red;
  logic               w_need_yellow;
  logic               w_has_next;
  logic [2:0]         w_next_slot;
  logic [2:0]         w_next_type;
  logic [15:0]        w_next_data;

  assign w_accept = (r_state == ST_IDLE) && r_ready && req_valid_i;
  assign w_reject = (req_op_i == c_op_reconfig) &&
                    ((req_green_ms_i == 16'd0) || (req_red_ms_i == 16'd0) ||
                     (req_yellow_ms_i == 16'd0));

  // First command is known straight from the request; RECONFIG always opens
  // with BLINK so the controller is safe before any timing write.
  always_comb begin
    w_first_type = c_cmd_on;
    case (req_op_i)
      c_op_on:       w_first_type = c_cmd_on;
      c_op_off:      w_first_type = c_cmd_off;
      c_op_blink:    w_first_type = c_cmd_blink;
      c_op_reconfig: w_first_type = c_cmd_blink;
      default:       w_first_type = c_cmd_on;
    endcase
  end

`ifdef TRAFFIC_CMD_SEQ_SKIP_UNCHANGED_EN
  // Mirror of the timings currently loaded in the controller; reset values
  // match the controller's own reset defaults.
  logic [15:0] r_shadow_green;
  logic [15:0] r_shadow_red;
  logic [15:0] r_shadow_yellow;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_shadow_green  <= 16'd50;
      r_shadow_red    <= 16'd2;
      r_shadow_yellow <= 16'd30;
    end else if (w_valid_n) begin
      if (w_type_n == c_cmd_green)  r_shadow_green  <= w_data_n;
      if (w_type_n == c_cmd_red)    r_shadow_red    <= w_data_n;
      if (w_type_n == c_cmd_yellow) r_shadow_yellow <= w_data_n;
    end
  end

  assign w_need_green  = (r_green  != r_shadow_green);
  assign w_need_red    = (r_red    != r_shadow_red);
  assign w_need_yellow = (r_yellow != r_shadow_yellow);
`else
  assign w_need_green  = 1'b1;
  assign w_need_red    = 1'b1;
  assign w_need_yellow = 1'b1;
`endif

  // Next slot after the current one, skipping timing writes not needed.
  // The final ON slot is always issued, so the index never passes slot 4.
  always_comb begin
    w_has_next  = (r_op == c_op_reconfig) && (r_idx < c_slot_last);
    w_next_slot = c_slot_last;
    if ((r_idx < c_slot_green) && w_need_green) begin
      w_next_slot = c_slot_green;
    end else if ((r_idx < c_slot_red) && w_need_red) begin
      w_next_slot = c_slot_red;
    end else if ((r_idx < c_slot_yellow) && w_need_yellow) begin
      w_next_slot = c_slot_yellow;
    end
  end

  always_comb begin
    w_next_type = c_cmd_on;
    w_next_data = 16'd0;
    case (w_next_slot)
      c_slot_green: begin
        w_next_type = c_cmd_green;
        w_next_data = r_green;
      end
      c_slot_red: begin
        w_next_type = c_cmd_red;
        w_next_data = r_red;
      end
      c_slot_yellow: begin
        w_next_type = c_cmd_yellow;
        w_next_data = r_yellow;
      end
      default: begin
        w_next_type = c_cmd_on;
        w_next_data = 16'd0;
      end
    endcase
  end

  // Next-state and next-output logic; every output is registered so the
  // controller never sees a combinational path from req_*.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_valid_n = 1'b0;
    w_type_n  = c_cmd_on;
    w_data_n  = 16'd0;
    w_ready_n = r_ready;
    w_err_n   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ready_n = 1'b1;
        if (w_accept) begin
          if (w_reject) begin
            w_err_n = 1'b1;
          end else begin
            w_state_n = ST_ISSUE;
            w_idx_n   = c_slot_first;
            w_valid_n = 1'b1;
            w_type_n  = w_first_type;
            w_ready_n = 1'b0;
          end
        end
      end

      ST_ISSUE: begin
        if (GAP_CYCLES > 0) begin
          w_state_n = ST_GAP;
          w_cnt_n   = c_gap_load;
        end else if (w_has_next) begin
          w_idx_n   = w_next_slot;
          w_valid_n = 1'b1;
          w_type_n  = w_next_type;
          w_data_n  = w_next_data;
        end else begin
          w_state_n = ST_IDLE;
          w_ready_n = 1'b1;
        end
      end

      ST_GAP: begin
        if (r_cnt == '0) begin
          if (w_has_next) begin
            w_state_n = ST_ISSUE;
            w_idx_n   = w_next_slot;
            w_valid_n = 1'b1;
            w_type_n  = w_next_type;
            w_data_n  = w_next_data;
          end else begin
            w_state_n = ST_IDLE;
            w_ready_n = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
        w_ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= ST_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_op        <= 2'd0;
      r_green     <= 16'd0;
      r_red       <= 16'd0;
      r_yellow    <= 16'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= 3'd0;
      r_cmd_data  <= 16'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_cnt       <= w_cnt_n;
      r_cmd_valid <= w_valid_n;
      r_cmd_type  <= w_type_n;
      r_cmd_data  <= w_data_n;
      r_ready     <= w_ready_n;
      r_busy      <= !w_ready_n;
      r_err       <= w_err_n;
      if (w_accept) begin
        r_op     <= req_op_i;
        r_green  <= req_green_ms_i;
        r_red    <= req_red_ms_i;
        r_yellow <= req_yellow_ms_i;
      end
    end
  end

  assign req_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
  assign cmd_valid_o = r_cmd_valid;
  assign cmd_type_o  = r_cmd_type;
  assign cmd_data_o  = r_cmd_data;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lights_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_lights_cmd_seq
// Purpose  : Self-checking bench for traffic_lights_cmd_seq. Expected command
//            lists come from a request-level reference model (queues plus a
//            shadow array of controller timings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_lights_cmd_seq;

  localparam int G = 2;
`ifdef TRAFFIC_CMD_SEQ_SKIP_UNCHANGED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid, req_valid0;
  logic [1:0]  req_op;
  logic [15:0] req_g, req_r, req_y;

  logic        ready, cvalid, busy, err;
  logic [2:0]  ctype;
  logic [15:0] cdata;
  logic        ready0, cvalid0, busy0, err0;
  logic [2:0]  ctype0;
  logic [15:0] cdata0;

  always #5 clk = ~clk;

  traffic_lights_cmd_seq #(.GAP_CYCLES(G)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .req_valid_i(req_valid), .req_ready_o(ready), .req_op_i(req_op),
    .req_green_ms_i(req_g), .req_red_ms_i(req_r), .req_yellow_ms_i(req_y),
    .cmd_valid_o(cvalid), .cmd_type_o(ctype), .cmd_data_o(cdata),
    .busy_o(busy), .err_o(err)
  );

  traffic_lights_cmd_seq #(.GAP_CYCLES(0)) dut0 (
    .clk_i(clk), .arst_n_i(arst_n),
    .req_valid_i(req_valid0), .req_ready_o(ready0), .req_op_i(req_op),
    .req_green_ms_i(req_g), .req_red_ms_i(req_r), .req_yellow_ms_i(req_y),
    .cmd_valid_o(cvalid0), .cmd_type_o(ctype0), .cmd_data_o(cdata0),
    .busy_o(busy0), .err_o(err0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_shadow [3];
  bit          m_rej;
  int          q_type [$];
  int          q_data [$];

  function automatic void model_reset();
    m_shadow[0] = 16'd50;
    m_shadow[1] = 16'd2;
    m_shadow[2] = 16'd30;
  endfunction

  function automatic void model(input logic [1:0] op, input logic [15:0] gg,
                                input logic [15:0] rr, input logic [15:0] yy);
    logic [15:0] t [3];
    t[0] = gg; t[1] = rr; t[2] = yy;
    q_type.delete(); q_data.delete(); m_rej = 1'b0;
    if (op != 2'd3) begin
      q_type.push_back(int'(op)); q_data.push_back(0);
    end else if (gg == 0 || rr == 0 || yy == 0) begin
      m_rej = 1'b1;
    end else begin
      q_type.push_back(2); q_data.push_back(0);
      for (int i = 0; i < 3; i++) begin
        if (!SKIP || t[i] != m_shadow[i]) begin
          q_type.push_back(3 + i); q_data.push_back(int'(t[i]));
          m_shadow[i] = t[i];
        end
      end
      q_type.push_back(0); q_data.push_back(0);
    end
  endfunction

  // Called at a falling edge; returns at the falling edge of the first cycle
  // in which the sequencer is ready again.
  task automatic do_req(input logic [1:0] op, input logic [15:0] gg, input logic [15:0] rr,
                        input logic [15:0] yy, input bit hold, input logic [1:0] nop,
                        input logic [15:0] ng, input logic [15:0] nr, input logic [15:0] ny);
    int w;
    bit acc;
    int len;
    req_op = op; req_g = gg; req_r = rr; req_y = yy; req_valid = 1'b1;
    w = 0; acc = 1'b0;
    forever begin
      acc = (ready === 1'b1);
      @(posedge clk);
      if (acc || w >= 40) break;
      w++;
      @(negedge clk);
    end
    chk("accept", 32'(acc), 32'd1);
    if (!acc) begin
      req_valid = 1'b0;
      @(negedge clk);
      return;
    end
    model(op, gg, rr, yy);
    #1;
    if (hold && !m_rej) begin
      req_op = nop; req_g = ng; req_r = nr; req_y = ny;
    end else begin
      req_valid = 1'b0;
      req_op = 2'($urandom); req_g = 16'($urandom);
      req_r = 16'($urandom); req_y = 16'($urandom);
    end
    if (m_rej) begin
      @(negedge clk);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_valid", 32'(cvalid), 32'd0);
      chk("rej_ready", 32'(ready), 32'd1);
      @(negedge clk);
      chk("rej_err_clr", 32'(err), 32'd0);
      chk("rej_ready2", 32'(ready), 32'd1);
      return;
    end
    len = q_type.size();
    for (int c = 1; c <= len * (G + 1); c++) begin
      int  k;
      bit  pulse;
      @(negedge clk);
      k = (c - 1) / (G + 1);
      pulse = ((c - 1) % (G + 1)) == 0;
      chk("cmd_valid", 32'(cvalid), 32'(pulse));
      chk("cmd_data", 32'(cdata), pulse ? 32'(q_data[k]) : 32'd0);
      if (pulse) chk("cmd_type", 32'(ctype), 32'(q_type[k]));
      chk("ready_low", 32'(ready), 32'd0);
      chk("busy_high", 32'(busy), 32'd1);
      chk("err_low", 32'(err), 32'd0);
    end
    @(negedge clk);
    chk("ready_back", 32'(ready), 32'd1);
    chk("busy_back", 32'(busy), 32'd0);
    chk("valid_back", 32'(cvalid), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'd50;
      2:       return 16'd2;
      3:       return 16'd30;
      4:       return 16'd40;
      default: return 16'($urandom_range(1, 65535));
    endcase
  endfunction

  localparam int NR = 24;
  logic [1:0]  r_op [NR+1];
  logic [15:0] r_g  [NR+1];
  logic [15:0] r_r  [NR+1];
  logic [15:0] r_y  [NR+1];

  initial begin
    int et [5];
    int ed [5];
    et = '{2, 3, 4, 5, 0};
    ed = '{0, 40, 7, 12, 0};

    arst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
    req_op = 2'd0; req_g = 16'd0; req_r = 16'd0; req_y = 16'd0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(cvalid), 32'd0);
    chk("rst_type", 32'(ctype), 32'd0);
    chk("rst_data", 32'(cdata), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready0", 32'(ready0), 32'd0);
    arst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 32'd1);
    chk("ready0_after_rst", 32'(ready0), 32'd1);

    // back-to-back instance: five consecutive pulses, ready one cycle later
    req_op = 2'd3; req_g = 16'd40; req_r = 16'd7; req_y = 16'd12; req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("g0_valid", 32'(cvalid0), 32'd1);
      chk("g0_type", 32'(ctype0), 32'(et[c]));
      chk("g0_data", 32'(cdata0), 32'(ed[c]));
      chk("g0_busy", 32'(busy0), 32'd1);
    end
    @(negedge clk);
    chk("g0_ready", 32'(ready0), 32'd1);
    chk("g0_valid_end", 32'(cvalid0), 32'd0);
    chk("g0_err", 32'(err0), 32'd0);

    // directed requests on the gapped instance
    do_req(2'd3, 16'd50, 16'd9, 16'd30, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    do_req(2'd3, 16'd50, 16'd9, 16'd30, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    do_req(2'd2, 16'd0, 16'd0, 16'd0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    do_req(2'd3, 16'd40, 16'd7, 16'd12, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    do_req(2'd3, 16'd40, 16'd0, 16'd12, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    do_req(2'd1, 16'd5, 16'd5, 16'd5, 1'b1, 2'd0, 16'd1, 16'd1, 16'd1);
    do_req(2'd0, 16'd1, 16'd1, 16'd1, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

    // reset during the third command's gap
    req_op = 2'd3; req_g = 16'd41; req_r = 16'd8; req_y = 16'd13; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(cvalid), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(cdata), 32'd0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_valid", 32'(cvalid), 32'd0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_valid", 32'(cvalid), 32'd0);
    do_req(2'd0, 16'd0, 16'd0, 16'd0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);

    // randomized requests, sometimes holding valid through the busy window
    for (int i = 0; i <= NR; i++) begin
      r_op[i] = 2'($urandom_range(0, 3));
      r_g[i] = pick(); r_r[i] = pick(); r_y[i] = pick();
    end
    for (int i = 0; i < NR; i++) begin
      bit h;
      h = ($urandom_range(0, 1) == 1) && (i < NR - 1);
      do_req(r_op[i], r_g[i], r_r[i], r_y[i], h, r_op[i+1], r_g[i+1], r_r[i+1], r_y[i+1]);
      if (!(h && req_valid)) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
